approx_mant_seqmul: RTL and testbench

Sequential, precision-adaptive BF16 mantissa multiplier; the consumer of the 11-bit product precision mask produced by the precision controller. It accepts two 8-bit significands (hidden bit included) with a mask and runs a radix-2 shift-add MSB-first. The iteration count is derived from the mask, so low-precision products finish in fewer cycles. It returns a 16-bit significand product truncated to the mask. It sits between operand unpack/precision control and exponent adjust/normalise in the approximate multiplier datapath.

---
 rtl/bf16_approx_pkg.sv | 20 ++
 rtl/prec_mask_decode.sv | 30 +++
 rtl/approx_mant_seqmul.sv | 102 ++++++++++
 tb/tb_approx_mant_seqmul.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_approx_pkg.sv
// Shared types and constants for the approximate BF16 multiplier datapath.
package bf16_approx_pkg;

  localparam int MANT_W       = 8;
  localparam int MASK_W       = 11;
  localparam int PROD_W       = 2 * MANT_W;
  localparam int BW_MIN       = 4;
  localparam int PROD_LSB_PAD = PROD_W - MASK_W;

  // Wide enough for N (up to MASK_W) and the iteration counter.
  localparam int CNT_W = 4;
  localparam int IDX_W = $clog2(MANT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prec_mask_decode.sv
// Decodes a product precision mask into kept-bit count N, iteration count
// and a clean thermometer mask with the BW_MIN floor applied.
module prec_mask_decode
  import bf16_approx_pkg::*;
(
  input  logic [MASK_W-1:0] mask,
  output logic [CNT_W-1:0]  n,
  output logic [CNT_W-1:0]  iter,
  output logic [MASK_W-1:0] mask_eff
);

  logic [CNT_W-1:0] lead;
  logic             in_run;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lead   = '0;
    in_run = 1'b1;
    // Only the unbroken run of ones from the MSB counts; a zero ends it.
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (in_run && mask[i]) lead = lead + CNT_W'(1);
      else                   in_run = 1'b0;
    end
    n        = (lead < CNT_W'(BW_MIN)) ? CNT_W'(BW_MIN) : lead;
    iter     = (n > CNT_W'(MANT_W)) ? CNT_W'(MANT_W) : n;
    mask_eff = {MASK_W{1'b1}} << (CNT_W'(MASK_W) - n);
  end

endmodule

// File: rtl/approx_mant_seqmul.sv
// Precision-adaptive sequential significand multiplier: MSB-first radix-2
// shift-add whose iteration count shrinks with the requested precision.
module approx_mant_seqmul
  import bf16_approx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  input  logic [MASK_W-1:0] mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod,
  output logic              busy
);

  state_e            state;
  logic [MANT_W-1:0] a_q;
  logic [MANT_W-1:0] b_q;
  logic [MASK_W-1:0] mask_q;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_next;
  logic [PROD_W-1:0] partial;

  logic [CNT_W-1:0]  dec_n;
  logic [CNT_W-1:0]  dec_iter;
  logic [MASK_W-1:0] dec_mask_eff;

  prec_mask_decode u_decode (
    .mask     (mask),
    .n        (dec_n),
    .iter     (dec_iter),
    .mask_eff (dec_mask_eff)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    partial = '0;
    if (b_q[idx]) partial = PROD_W'(a_q) << idx;
    acc_next = acc + partial;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mask_q    <= '0;
      idx       <= '0;
      cnt       <= '0;
      acc       <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= mant_a;
            b_q    <= mant_b;
            mask_q <= dec_mask_eff;
            cnt    <= dec_iter;
            idx    <= IDX_W'(MANT_W - 1);
            acc    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            // The final partial product folds straight into the output register.
            prod      <= acc_next & {mask_q, {PROD_LSB_PAD{1'b0}}};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc <= acc_next;
            idx <= idx - IDX_W'(1);
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The decoder must always honour the minimum precision floor.
  assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready) |-> (dec_n >= CNT_W'(BW_MIN)));

endmodule

// File: tb/tb_approx_mant_seqmul.sv
// Self-checking bench for approx_mant_seqmul: vector table, scoreboard queue,
// and hand-written stall / ignored-input / mid-run reset sequences.
module tb_approx_mant_seqmul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mant_a;
  logic [7:0]  mant_b;
  logic [10:0] mask;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [10:0] mask;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  approx_mant_seqmul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_a    (mant_a),
    .mant_b    (mant_b),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: multiply by the retained multiplier bits, then keep the top N
  // product bits.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [10:0] m);
    exp_t        r;
    int          lead;
    int          n;
    logic [7:0]  keep_b;
    logic [7:0]  ones8;
    logic [15:0] ones16;
    lead = 0;
    while (lead < 11 && m[10 - lead]) lead++;
    n      = (lead < 4) ? 4 : lead;
    r.lat  = (n > 8) ? 8 : n;
    ones8  = 8'hFF;
    ones16 = 16'hFFFF;
    keep_b = b & (ones8 << (8 - r.lat));
    r.prod = (16'(a) * 16'(keep_b)) & (ones16 << (16 - n));
    return r;
  endfunction

  // One full transaction starting and ending on a negedge in IDLE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [10:0] m,
                       input logic [15:0] ep, input int el, input int stall, input bit noise);
    exp_t e;
    int   lat;
    bit   got;
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    mant_a    = a;
    mant_b    = b;
    mask      = m;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    e.prod = ep;
    e.lat  = el;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Operands are latched: scramble them so late changes would be visible.
    in_valid = noise;
    mant_a   = ~a;
    mant_b   = ~b;
    mask     = 11'h000;
    check("busy_rdy_vld_after_accept", 32'({busy, in_ready, out_valid}), 32'b100);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) got = 1;
    end
    in_valid = 1'b0;
    if (!got) check("out_valid_timeout", 32'(got), 32'd1);
    e = sb_q.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("prod", 32'(prod), 32'(e.prod));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_vld_rdy", 32'({out_valid, in_ready}), 32'b10);
      check("stall_prod", 32'(prod), 32'(e.prod));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handshake", 32'({in_ready, busy, out_valid}), 32'b100);
  endtask

  vec_t vecs[8];

  initial begin
    exp_t r;
    int   saw;

    vecs[0] = '{a: 8'h80, b: 8'h80, mask: 11'h7FF,          prod: 16'h4000, lat: 8};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, mask: 11'h7FF,          prod: 16'hFE00, lat: 8};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, mask: 11'b11110000000,  prod: 16'hE000, lat: 4};
    vecs[3] = '{a: 8'hC0, b: 8'hC0, mask: 11'b11011111111,  prod: 16'h9000, lat: 4};
    vecs[4] = '{a: 8'h80, b: 8'hFF, mask: 11'h000,          prod: 16'h7000, lat: 4};
    vecs[5] = '{a: 8'h81, b: 8'hFF, mask: 11'b11111110000,  prod: 16'h7E00, lat: 7};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, mask: 11'b11111111110,  prod: 16'hFE00, lat: 8};
    vecs[7] = '{a: 8'hB5, b: 8'h9C, mask: 11'b11111111000,  prod: 16'h6E00, lat: 8};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_a    = '0;
    mant_b    = '0;
    mask      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_state", 32'({in_ready, busy, out_valid}), 32'b100);
    check("reset_prod", 32'(prod), 32'd0);

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].mask, vecs[i].prod, vecs[i].lat, 0, 1'b0);

    // Held output under backpressure, with in_valid asserted during RUN.
    do_op(8'hFF, 8'hFF, 11'b11110000000, 16'hE000, 4, 5, 1'b1);
    do_op(8'hC0, 8'hC0, 11'b11011111111, 16'h9000, 4, 0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [7:0]  a;
      logic [7:0]  b;
      logic [10:0] m;
      logic [10:0] th;
      logic [10:0] full;
      int          k;
      a    = 8'($urandom_range(128, 255));
      b    = 8'($urandom_range(128, 255));
      k    = $urandom_range(0, 11);
      full = 11'h7FF;
      th   = full << (11 - k);
      m    = th | (11'($urandom) & ~(th >> 1));
      r    = model(a, b, m);
      do_op(a, b, m, r.prod, r.lat, i % 3, 1'b0);
    end

    // Reset two cycles into an 8-cycle run must discard the operation.
    check("in_ready_before_reset_op", 32'(in_ready), 32'd1);
    mant_a    = 8'hFF;
    mant_b    = 8'hFF;
    mask      = 11'h7FF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_run_reset_state", 32'({in_ready, busy, out_valid}), 32'b100);
    check("mid_run_reset_prod", 32'(prod), 32'd0);
    saw = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) saw++;
    end
    check("no_stale_output", 32'(saw), 32'd0);
    out_ready = 1'b0;

    do_op(8'h80, 8'h80, 11'h7FF, 16'h4000, 8, 0, 1'b0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
